// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
//   Shared types and constants for the FPU writeback slice.
//   reg_idx_t  : architectural register index (32 registers)
//   fpu_wb_t   : one buffered FPU result (destination + 32-bit data)
//   FPU_WB_DEPTH_DEFAULT : default result buffer depth
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int FPU_WB_DEPTH_DEFAULT = 4;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t    dest;
    logic [31:0] data;
  } fpu_wb_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// ---------------------------------------------------------------------------
// fpu_wb_fifo
//   Small synchronous FIFO holding FPU results until the shared register
//   file write port is free.
//   Ports:
//     clock, reset_n  : clock and asynchronous active-low reset
//     push, push_entry: write request and payload
//     pop, pop_entry  : read request and head-of-queue payload (show-ahead)
//     full, empty     : status flags
//     count           : number of valid entries (0..DEPTH)
//   A push while full is only accepted when a pop happens in the same cycle;
//   otherwise it is ignored and the caller is expected to flag the loss.
// ---------------------------------------------------------------------------
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = FPU_WB_DEPTH_DEFAULT,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  fpu_wb_t       push_entry,
  input  logic          pop,
  output fpu_wb_t       pop_entry,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fpu_wb_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // When full, the slot being vacated by a same-cycle pop receives the push.
  assign do_push   = push && (!full || do_pop);
  assign pop_entry = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define which slots are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fpu_writeback.sv
// ---------------------------------------------------------------------------
// fpu_writeback
//   Consumer end of the FPU result stream. Buffers results, merges them into
//   the shared register file write port (integer pipeline has priority),
//   tracks in-flight FPU destinations for decode hazard detection, and
//   hands out issue credits so the FPU can never overrun the buffer.
//
//   Ports:
//     clock, reset_n       : clock, asynchronous active-low reset
//     fpu_issue_valid/dest : decode issuing an FPU op (qualified by ready)
//     fpu_issue_ready      : credit available
//     fpu_valid/dest/result: FPU result stream
//     cpu_wb_valid         : integer pipeline owns the RF write port
//     hz_reg_a/b/d         : decode registers to hazard-check
//     fpu_hazard           : any of hz_reg_a/b/d has a pending FPU write
//     rf_write_valid/dest/data : registered RF write port
//     fpu_overflow         : sticky, a result was dropped on a full buffer
//
//   Optional macro FPU_WB_CHECK_EN adds sticky output fpu_wb_error, set when
//   a result is popped for a register with no pending op, or an issue would
//   saturate a pending counter.
// ---------------------------------------------------------------------------
module fpu_writeback
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH = FPU_WB_DEPTH_DEFAULT,
  parameter int CNT_W      = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fpu_issue_valid,
  input  logic [4:0]  fpu_issue_dest,
  output logic        fpu_issue_ready,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_dest,
  input  logic [31:0] fpu_result,
  input  logic        cpu_wb_valid,
  input  logic [4:0]  hz_reg_a,
  input  logic [4:0]  hz_reg_b,
  input  logic [4:0]  hz_reg_d,
  output logic        fpu_hazard,
  output logic        rf_write_valid,
  output logic [4:0]  rf_write_dest,
  output logic [31:0] rf_write_data,
  output logic        fpu_overflow
`ifdef FPU_WB_CHECK_EN
  ,
  output logic        fpu_wb_error
`endif
);

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW  = FAW + 1;
  localparam logic [OW-1:0]    OUT_MAX  = OW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  logic             issue_accept;
  logic [OW-1:0]    outstanding;
  fpu_wb_t          push_entry;
  fpu_wb_t          pop_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FAW:0]     fifo_count;
  logic             fifo_pop;
  logic             drop;
  logic [CNT_W-1:0] pending [32];
  logic [31:0]      pend_inc;
  logic [31:0]      pend_dec;

  assign issue_accept    = fpu_issue_valid && fpu_issue_ready;
  assign fpu_issue_ready = (outstanding < OUT_MAX);

  assign push_entry.dest = fpu_dest;
  assign push_entry.data = fpu_result;

  // The integer pipeline always wins the shared write port.
  assign fifo_pop = (fifo_count != '0) && !fifo_empty && !cpu_wb_valid;
  assign drop     = fpu_valid && fifo_full && !fifo_pop;

  fpu_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (fpu_valid),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .pop_entry  (pop_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Credit counter: one credit per buffer slot, returned when the result
  // actually reaches the register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({issue_accept, rf_write_valid})
        2'b10:   if (outstanding != OUT_MAX) outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0)      outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Registered write port; dest/data hold their last value when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_valid <= 1'b0;
      rf_write_dest  <= '0;
      rf_write_data  <= '0;
    end else begin
      rf_write_valid <= fifo_pop;
      if (fifo_pop) begin
        rf_write_dest <= pop_entry.dest;
        rf_write_data <= pop_entry.data;
      end
    end
  end

  // Sticky record that a result was lost to a full buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fpu_overflow <= 1'b0;
    end else if (drop) begin
      fpu_overflow <= 1'b1;
    end
  end

  // Per-register increment/decrement requests; r0 is never tracked.
  always_comb begin
    pend_inc = '0;
    pend_dec = '0;
    if (issue_accept)   pend_inc[fpu_issue_dest] = 1'b1;
    if (rf_write_valid) pend_dec[rf_write_dest]  = 1'b1;
    pend_inc[0] = 1'b0;
    pend_dec[0] = 1'b0;
  end

  // Saturating pending counters; a same-cycle issue and write cancel out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) pending[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (pend_inc[r] && !pend_dec[r] && (pending[r] != PEND_MAX))
          pending[r] <= pending[r] + 1'b1;
        else if (pend_dec[r] && !pend_inc[r] && (pending[r] != '0))
          pending[r] <= pending[r] - 1'b1;
      end
    end
  end

  // No forwarding from the buffer: a register stays hazarded until its
  // write has left the port.
  assign fpu_hazard = (pending[hz_reg_a] != '0) ||
                      (pending[hz_reg_b] != '0) ||
                      (pending[hz_reg_d] != '0);

`ifdef FPU_WB_CHECK_EN
  logic pop_unexpected;
  logic issue_saturate;

  assign pop_unexpected = fifo_pop && (pop_entry.dest != '0) &&
                          (pending[pop_entry.dest] == '0);
  assign issue_saturate = pend_inc[fpu_issue_dest] && !pend_dec[fpu_issue_dest] &&
                          (pending[fpu_issue_dest] == PEND_MAX);

  // Sticky consistency error between issue bookkeeping and result stream.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fpu_wb_error <= 1'b0;
    end else if (pop_unexpected || issue_saturate) begin
      fpu_wb_error <= 1'b1;
      if (pop_unexpected)
        $display("fpu_writeback: result popped for r%0d with no pending op", pop_entry.dest);
      if (issue_saturate)
        $display("fpu_writeback: issue to r%0d saturates pending counter", fpu_issue_dest);
    end
  end
`endif

endmodule
